// File: rtl/monta_senha_if.sv
// Payload type and keypad/checker-side bus for the password packer.
// The package lives here so the packed payload is shared by the bus, the packer and the checker.
package monta_senha_pkg;
  localparam int unsigned DIGITS = 20;

  // digits[0] is the first digit typed (least significant nibble)
  typedef struct packed {
    logic [DIGITS-1:0][3:0] digits;
  } senhaPac_t;
endpackage

interface monta_senha_if;
  import monta_senha_pkg::*;

  logic        key_valid;
  logic [3:0]  key_code;
  logic        verif_done;
  senhaPac_t   senha_out;
  logic        senha_valid;
  logic [4:0]  digit_count;
  logic        busy;
  logic        timeout;

  modport slave (
    input  key_valid, key_code, verif_done,
    output senha_out, senha_valid, digit_count, busy, timeout
  );

  modport master (
    output key_valid, key_code, verif_done,
    input  senha_out, senha_valid, digit_count, busy, timeout
  );
endinterface

// File: rtl/monta_senha.sv
// Keypad-side packer: collects digits into a senhaPac_t, sends it on ENTER and holds it
// until the checker reports done. Supports backspace, inactivity timeout and a sliding window.
module monta_senha
  import monta_senha_pkg::*;
#(
  parameter int unsigned MAX_DIGITS     = 20,
  parameter int unsigned TIMEOUT_CYCLES = 5000,
  parameter int unsigned TO_W           = 13
) (
  input  logic           clk,
  input  logic           rst,
  monta_senha_if.slave   bus
);

  localparam int unsigned CNT_W = 5;

  typedef enum logic [1:0] {VAZIO, COLETANDO, ENVIA, AGUARDA} state_t;

  state_t             state, state_nx;
  senhaPac_t          pac_q, pac_nx;
  logic [CNT_W-1:0]   cnt_q, cnt_nx;
  logic [TO_W-1:0]    to_q, to_nx;
  logic               timeout_q, timeout_nx;
  logic               valid_q, busy_q;

  logic is_digit, is_bs, is_enter, is_accepted;

  always_comb begin
    is_digit    = (bus.key_code <= 4'h9);
    is_bs       = (bus.key_code == 4'hA);
    is_enter    = (bus.key_code == 4'hB);
    is_accepted = bus.key_valid && (bus.key_code <= 4'hB);
  end

  // Next-state and next-buffer logic
  always_comb begin
    state_nx   = state;
    pac_nx     = pac_q;
    cnt_nx     = cnt_q;
    to_nx      = to_q;
    timeout_nx = 1'b0;

    case (state)
      VAZIO: begin
        to_nx = '0;
        if (bus.key_valid && is_digit) begin
          pac_nx.digits[0] = bus.key_code;
          cnt_nx           = CNT_W'(1);
          state_nx         = COLETANDO;
        end
      end

      COLETANDO: begin
        if (is_accepted) begin
          // A key always beats a simultaneous expiry
          to_nx = '0;
          if (is_digit) begin
            if (cnt_q < CNT_W'(MAX_DIGITS)) begin
              pac_nx.digits[cnt_q] = bus.key_code;
              cnt_nx               = cnt_q + CNT_W'(1);
            end else begin
              pac_nx.digits = {bus.key_code, pac_q.digits[DIGITS-1:1]};
            end
          end else if (is_bs) begin
            pac_nx.digits[cnt_q - CNT_W'(1)] = 4'hF;
            cnt_nx                           = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) state_nx = VAZIO;
          end else if (is_enter) begin
            state_nx = ENVIA;
          end
        end else if (to_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
          pac_nx     = '1;
          cnt_nx     = '0;
          to_nx      = '0;
          timeout_nx = 1'b1;
          state_nx   = VAZIO;
        end else begin
          to_nx = to_q + TO_W'(1);
        end
      end

      ENVIA: begin
        to_nx    = '0;
        state_nx = AGUARDA;
      end

      AGUARDA: begin
        to_nx = '0;
        if (bus.verif_done) begin
          pac_nx   = '1;
          cnt_nx   = '0;
          state_nx = VAZIO;
        end
      end

      default: state_nx = VAZIO;
    endcase
  end

  // State and output registers; valid/busy are registered decodes of the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= VAZIO;
      pac_q     <= '1;
      cnt_q     <= '0;
      to_q      <= '0;
      timeout_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nx;
      pac_q     <= pac_nx;
      cnt_q     <= cnt_nx;
      to_q      <= to_nx;
      timeout_q <= timeout_nx;
      valid_q   <= (state_nx == ENVIA);
      busy_q    <= (state_nx == ENVIA) || (state_nx == AGUARDA);
    end
  end

  assign bus.senha_out   = pac_q;
  assign bus.senha_valid = valid_q;
  assign bus.digit_count = cnt_q;
  assign bus.busy        = busy_q;
  assign bus.timeout     = timeout_q;

endmodule
